// File: rtl/flb_band_cal_ctrl.sv
// Band-calibration sequencer for the FLB.
// An 8-step SAR search picks the coarse band word by trying each bit, waiting
// for the loop to settle and averaging dlf_out. After calibration it can
// track by nudging band +/-1 while dlf_out stays near a rail. It also holds
// sdm_on low while a search is running.
module flb_band_cal_ctrl #(
  parameter int unsigned AVG_LOG2    = 2,
  parameter logic [7:0]  BAND_RST    = 8'd128,
  parameter logic [15:0] TRK_HI      = 16'hC000,
  parameter logic [15:0] TRK_LO      = 16'h4000,
  parameter int unsigned TRK_PERSIST = 8
) (
  input  logic        ref_clk,
  input  logic        rst_n,
  input  logic        cal_start,
  input  logic        cal_abort,
  input  logic        trk_en,
  input  logic        sdm_on_req,
  input  logic [7:0]  settle_cyc,
  input  logic [15:0] dlf_out,
  output logic [7:0]  band,
  output logic        sdm_on,
  output logic        cal_busy,
  output logic        cal_done,
  output logic        cal_fail,
  output logic [1:0]  trk_step
);

  localparam int unsigned SUM_W    = 16 + AVG_LOG2;
  localparam logic [7:0]  MEAS_LEN = 8'(1 << AVG_LOG2);
  localparam logic [7:0]  PERSIST  = 8'(TRK_PERSIST);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_SETTLE, S_MEAS, S_DECIDE, S_DONE, S_FAIL
  } state_e;

  state_e           state_q;
  logic [2:0]       k_q;          // bit currently under trial
  logic [7:0]       result_q;     // bits decided so far
  logic [SUM_W-1:0] sum_q;        // dlf_out accumulator for one step
  logic [7:0]       cnt_q;        // shared settle / measure down-counter
  logic [7:0]       trk_cnt_q;    // tracking persistence counter
  logic             trk_up_q;     // direction of the current persistence run
  logic [7:0]       band_q;
  logic             sdm_on_q;
  logic             cal_busy_q;
  logic             cal_done_q;
  logic             cal_fail_q;
  logic [1:0]       trk_step_q;

  logic [15:0] mean;
  logic        keep;
  logic [7:0]  result_nxt;
  logic        rail;
  logic        out_win;
  logic        start_ok;
  logic        busy_nxt;
  logic        up;
  logic        dn;
  logic [7:0]  trk_cnt_inc;

  // Step decision, start qualification, next busy level and tracking direction.
  always_comb begin
    // NOTE: every signal here is assigned on every path, so no latch is inferred.
    mean        = sum_q[SUM_W-1:AVG_LOG2];
    keep        = (mean >= 16'h8000);
    result_nxt  = result_q | ({7'd0, keep} << k_q);
    rail        = (result_nxt == 8'h00) || (result_nxt == 8'hFF);
    out_win     = (mean < TRK_LO) || (mean > TRK_HI);
    start_ok    = cal_start && (state_q inside {S_IDLE, S_DONE, S_FAIL});
    busy_nxt    = !cal_abort &&
                  (start_ok ||
                   (state_q inside {S_SET, S_SETTLE, S_MEAS}) ||
                   (state_q == S_DECIDE && k_q != 3'd0));
    up          = (dlf_out > TRK_HI);
    dn          = !up && (dlf_out < TRK_LO);
    trk_cnt_inc = (trk_cnt_q != 8'd0 && trk_up_q == up) ? trk_cnt_q + 8'd1 : 8'd1;
  end

  // Sequencer: SAR search, post-cal tracking and all registered outputs.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= 3'd7;
      result_q   <= 8'd0;
      sum_q      <= '0;
      cnt_q      <= 8'd0;
      trk_cnt_q  <= 8'd0;
      trk_up_q   <= 1'b0;
      band_q     <= BAND_RST;
      sdm_on_q   <= 1'b0;
      cal_busy_q <= 1'b0;
      cal_done_q <= 1'b0;
      cal_fail_q <= 1'b0;
      trk_step_q <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments, so every branch sees the pre-edge values.
      trk_step_q <= 2'b00;
      cal_busy_q <= busy_nxt;
      sdm_on_q   <= sdm_on_req & ~busy_nxt;
      if (cal_abort) begin
        state_q    <= S_IDLE;
        cal_done_q <= 1'b0;
        cal_fail_q <= 1'b0;
        sum_q      <= '0;
        trk_cnt_q  <= 8'd0;
      end else if (start_ok) begin
        state_q    <= S_SET;
        k_q        <= 3'd7;
        result_q   <= 8'd0;
        cal_done_q <= 1'b0;
        cal_fail_q <= 1'b0;
        trk_cnt_q  <= 8'd0;
      end else begin
        case (state_q)
          S_SET: begin
            band_q  <= result_q | (8'd1 << k_q);
            sum_q   <= '0;
            cnt_q   <= (settle_cyc == 8'd0) ? 8'd1 : settle_cyc;
            state_q <= S_SETTLE;
          end
          S_SETTLE: begin
            if (cnt_q <= 8'd1) begin
              cnt_q   <= MEAS_LEN;
              state_q <= S_MEAS;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          S_MEAS: begin
            sum_q <= sum_q + SUM_W'(dlf_out);
            if (cnt_q <= 8'd1) begin
              state_q <= S_DECIDE;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          S_DECIDE: begin
            result_q <= result_nxt;
            if (k_q == 3'd0) begin
              band_q <= result_nxt;
              if (rail && out_win) begin
                state_q    <= S_FAIL;
                cal_fail_q <= 1'b1;
              end else begin
                state_q    <= S_DONE;
                cal_done_q <= 1'b1;
              end
            end else begin
              k_q     <= k_q - 3'd1;
              state_q <= S_SET;
            end
          end
          S_DONE: begin
            if (!trk_en || !(up || dn)) begin
              trk_cnt_q <= 8'd0;
            end else begin
              trk_up_q <= up;
              if (trk_cnt_inc == PERSIST) begin
                trk_cnt_q <= 8'd0;
                if (up && band_q != 8'hFF) begin
                  band_q     <= band_q + 8'd1;
                  trk_step_q <= 2'b01;
                end else if (dn && band_q != 8'h00) begin
                  band_q     <= band_q - 8'd1;
                  trk_step_q <= 2'b10;
                end
              end else begin
                trk_cnt_q <= trk_cnt_inc;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign band     = band_q;
  assign sdm_on   = sdm_on_q;
  assign cal_busy = cal_busy_q;
  assign cal_done = cal_done_q;
  assign cal_fail = cal_fail_q;
  assign trk_step = trk_step_q;

endmodule

// File: tb/tb_flb_band_cal_ctrl.sv
// Directed bench for flb_band_cal_ctrl. A behavioural model describes the
// calibration as a position inside an arithmetic step timeline and checks
// every output on every falling edge. Literal expectations at key points
// pin both the model and the DUT.
`timescale 1ns/1ps
module tb_flb_band_cal_ctrl;

  localparam int N       = 4;        // samples per step, 2^AVG_LOG2
  localparam int TRK_HI  = 'hC000;
  localparam int TRK_LO  = 'h4000;
  localparam int PERSIST = 8;

  logic        ref_clk    = 1'b0;
  logic        rst_n      = 1'b1;
  logic        cal_start  = 1'b0;
  logic        cal_abort  = 1'b0;
  logic        trk_en     = 1'b0;
  logic        sdm_on_req = 1'b1;
  logic [7:0]  settle_cyc = 8'd3;
  logic [15:0] dlf_out;
  logic [7:0]  band;
  logic        sdm_on, cal_busy, cal_done, cal_fail;
  logic [1:0]  trk_step;

  // Plant: in threshold mode, a trial band at or below plant_thr reads high.
  int          plant_mode = 1;     // 0 = threshold plant, 1 = constant value
  logic [7:0]  plant_thr  = 8'h00;
  logic [15:0] plant_val  = 16'h8000;
  assign dlf_out = (plant_mode == 0) ? ((band <= plant_thr) ? 16'h9000 : 16'h7000)
                                     : plant_val;

  flb_band_cal_ctrl dut (
    .ref_clk    (ref_clk),
    .rst_n      (rst_n),
    .cal_start  (cal_start),
    .cal_abort  (cal_abort),
    .trk_en     (trk_en),
    .sdm_on_req (sdm_on_req),
    .settle_cyc (settle_cyc),
    .dlf_out    (dlf_out),
    .band       (band),
    .sdm_on     (sdm_on),
    .cal_busy   (cal_busy),
    .cal_done   (cal_done),
    .cal_fail   (cal_fail),
    .trk_step   (trk_step)
  );

  always #5 ref_clk = ~ref_clk;

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int t_start = 0;

  always @(posedge ref_clk) cyc++;

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUN, M_DONE, M_FAIL} mode_e;
  mode_e      m_mode = M_IDLE;
  int         m_k = 7, m_p = 0, m_len = 9, m_sum = 0, m_mean = 0, m_s = 1;
  int         m_pcnt = 0, m_pdir = 0, m_dir = 0;
  logic [7:0] m_res = 8'd0;
  logic [7:0] m_band = 8'd128;
  logic       m_busy = 1'b0, m_done = 1'b0, m_fail = 1'b0, m_sdm = 1'b0;
  logic [1:0] m_step = 2'b00;

  always @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_band = 8'd128; m_pcnt = 0; m_pdir = 0;
      m_busy = 1'b0; m_done = 1'b0; m_fail = 1'b0; m_sdm = 1'b0; m_step = 2'b00;
    end else begin
      m_step = 2'b00;
      if (cal_abort) begin
        m_mode = M_IDLE; m_pcnt = 0;
      end else if (cal_start && m_mode != M_RUN) begin
        m_mode = M_RUN; m_k = 7; m_p = 0; m_res = 8'd0; m_pcnt = 0;
      end else if (m_mode == M_RUN) begin
        // Step layout: position 0 trial, then settle, then N samples, then decision.
        if (m_p == 0) begin
          m_band = m_res | (8'd1 << m_k);
          m_sum  = 0;
          m_s    = (settle_cyc == 8'd0) ? 1 : int'(settle_cyc);
          m_len  = 2 + m_s + N;
        end else if (m_p >= m_len - 1 - N && m_p <= m_len - 2) begin
          m_sum += int'(dlf_out);
        end else if (m_p == m_len - 1) begin
          m_mean = m_sum / N;
          if (m_mean >= 'h8000) m_res[m_k] = 1'b1;
          if (m_k == 0) begin
            m_band = m_res;
            if ((m_res == 8'd0 || m_res == 8'd255) && (m_mean < TRK_LO || m_mean > TRK_HI))
              m_mode = M_FAIL;
            else
              m_mode = M_DONE;
          end else begin
            m_k--;
          end
        end
        m_p++;
        if (m_p == m_len) m_p = 0;
      end else if (m_mode == M_DONE) begin
        m_dir = (int'(dlf_out) > TRK_HI) ? 1 : (int'(dlf_out) < TRK_LO) ? -1 : 0;
        if (!trk_en || m_dir == 0) begin
          m_pcnt = 0;
        end else begin
          if (m_dir != m_pdir) m_pcnt = 0;
          m_pdir = m_dir;
          m_pcnt++;
          if (m_pcnt == PERSIST) begin
            m_pcnt = 0;
            if (m_dir > 0 && m_band != 8'd255) begin
              m_band++; m_step = 2'b01;
            end else if (m_dir < 0 && m_band != 8'd0) begin
              m_band--; m_step = 2'b10;
            end
          end
        end
      end
      m_busy = (m_mode == M_RUN);
      m_done = (m_mode == M_DONE);
      m_fail = (m_mode == M_FAIL);
      m_sdm  = sdm_on_req && !m_busy;
    end
  end

  // Every falling edge out of reset: all outputs against the model.
  always @(negedge ref_clk) begin
    if (rst_n === 1'b1) begin
      n_vec++;
      if (band !== m_band || cal_busy !== m_busy || cal_done !== m_done ||
          cal_fail !== m_fail || trk_step !== m_step || sdm_on !== m_sdm) begin
        n_mis++;
        $display("FAIL model_cmp t=%0t dut band=%h busy=%b done=%b fail=%b step=%b sdm=%b want band=%h busy=%b done=%b fail=%b step=%b sdm=%b",
                 $time, band, cal_busy, cal_done, cal_fail, trk_step, sdm_on,
                 m_band, m_busy, m_done, m_fail, m_step, m_sdm);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge ref_clk); #2 cal_start = 1'b1;
    @(posedge ref_clk); #1 t_start = cyc;
    #1 cal_start = 1'b0;
  endtask

  // Wait for done/fail; returns cycles from the edge that took cal_start.
  task automatic wait_end(output int cycles);
    while (!(cal_done || cal_fail)) begin
      if (cyc - t_start > 400) begin
        n_vec++; n_mis++;
        $display("FAIL cal_timeout: no done/fail after %0d cycles", cyc - t_start);
        break;
      end
      @(posedge ref_clk); #1;
    end
    cycles = cyc - t_start;
  endtask

  task automatic count_steps(input int ncyc, input logic [1:0] code, output int pulses);
    pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge ref_clk); #1;
      if (trk_step == code) pulses++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cycles;
    int pulses;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_band", band, 8'd128);
    check("rst_busy", cal_busy, 0);
    check("rst_done", cal_done, 0);
    check("rst_fail", cal_fail, 0);
    check("rst_step", trk_step, 0);
    check("rst_sdm",  sdm_on, 0);
    repeat (2) @(posedge ref_clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge ref_clk);

    // 1: SAR search converges on 8'h5A in 8*(1+3+4+1) cycles
    #2 plant_mode = 0; plant_thr = 8'h5A;
    pulse_start();
    wait_end(cycles);
    check("t1_latency", cycles, 72);
    check("t1_band", band, 8'h5A);
    check("t1_done", cal_done, 1);

    // 2: dlf pinned at the top rail -> band 8'hFF and FAIL; sdm gated while busy
    #1 plant_mode = 1; plant_val = 16'hFFFF;
    pulse_start();
    repeat (10) @(posedge ref_clk);
    #1;
    check("t2_sdm_busy", sdm_on, 0);
    check("t2_busy", cal_busy, 1);
    wait_end(cycles);
    check("t2_latency", cycles, 72);
    check("t2_fail", cal_fail, 1);
    check("t2_band", band, 8'hFF);
    check("t2_sdm_after", sdm_on, 1);

    // 3: calibrate to 8'h40, then track up once after 8 high samples
    #1 plant_mode = 0; plant_thr = 8'h40;
    pulse_start();
    wait_end(cycles);
    check("t3_cal_band", band, 8'h40);
    #1 trk_en = 1'b1; plant_mode = 1; plant_val = 16'hD000;
    count_steps(8, 2'b01, pulses);
    #1 plant_val = 16'h8000;
    begin
      int more;
      count_steps(2, 2'b01, more);
      pulses += more;
    end
    check("t3_up_pulses", pulses, 1);
    check("t3_band_up", band, 8'h41);
    #1 plant_val = 16'hD000;
    count_steps(7, 2'b01, pulses);
    #1 plant_val = 16'h8000;
    begin
      int more;
      count_steps(3, 2'b01, more);
      pulses += more;
    end
    check("t3_no_step", pulses, 0);
    check("t3_band_hold", band, 8'h41);

    // 4: abort during the 3rd SETTLE, then a full recalibration
    #1 trk_en = 1'b0; plant_mode = 0; plant_thr = 8'h5A;
    pulse_start();
    repeat (20) @(posedge ref_clk);
    #2 cal_abort = 1'b1;
    @(posedge ref_clk); #1;
    check("t4_abort_band", band, 8'h60);
    check("t4_abort_busy", cal_busy, 0);
    #1 cal_abort = 1'b0;
    repeat (3) @(posedge ref_clk);
    pulse_start();
    wait_end(cycles);
    check("t4_latency", cycles, 72);
    check("t4_band", band, 8'h5A);

    // 5: cal_start during MEAS is ignored; async reset mid-MEAS
    pulse_start();
    repeat (5) @(posedge ref_clk);
    #2 cal_start = 1'b1;
    @(posedge ref_clk); #2 cal_start = 1'b0;
    wait_end(cycles);
    check("t5_latency", cycles, 72);
    pulse_start();
    repeat (14) @(posedge ref_clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_band", band, 8'd128);
    check("t5_rst_busy", cal_busy, 0);
    @(posedge ref_clk); #2 rst_n = 1'b1;

    // 6: settle_cyc = 0 acts as 1; calibrate to 0 then hold at the bottom rail
    settle_cyc = 8'd0; plant_mode = 1; plant_val = 16'h7000;
    pulse_start();
    wait_end(cycles);
    check("t6_latency", cycles, 56);
    check("t6_band", band, 8'h00);
    #1 trk_en = 1'b1; plant_val = 16'h1000;
    count_steps(20, 2'b10, pulses);
    check("t6_no_step", pulses, 0);
    check("t6_band_sat", band, 8'h00);
    check("t6_done", cal_done, 1);
    #1 trk_en = 1'b0;
    repeat (2) @(posedge ref_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
